timer_host_master: RTL and testbench
====================================

# timer_host_master

Avalon-MM master sequencer that drives the 16-bit interval-timer slave (6-register map, 3-bit word address) without CPU involvement. It programs the period, starts continuous mode with interrupt enabled, services each timeout IRQ by clearing the status register, counts ticks, and performs snapshot reads on request. It sits beside the timer in the NIOS2_Design system as a hardware tick source for logic that must not depend on the Nios II core.

## Interface
Parameters:
- `CTRL_RUN`, default 4'h7: control word written at start (ITO | CONT | START).
- `CTRL_STOP`, default 4'h8: control word written on stop (STOP bit only).

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `cfg_start`  in  1  one-cycle pulse; latch `cfg_period` and begin programming. Ignored while `busy`.
- `cfg_stop`  in  1  one-cycle pulse; stop the timer. Ignored unless in RUN.
- `cfg_period`  in  32  timer period; sampled on an accepted `cfg_start`.
- `snap_req`  in  1  one-cycle pulse; request a counter snapshot. Ignored unless in RUN.
- `m_address`  out  3  timer word address.
- `m_chipselect`  out  1  bus access strobe.
- `m_write_n`  out  1  0 = write, 1 = read (when `m_chipselect` is high).
- `m_writedata`  out  16  write data.
- `m_readdata`  in  16  registered slave read data, valid one cycle after the read cycle.
- `irq_in`  in  1  timer IRQ, level.
- `busy`  out  1  high in every state except IDLE.
- `tick_pulse`  out  1  one-cycle pulse per serviced IRQ.
- `tick_count`  out  32  serviced-IRQ count.
- `snap_valid`  out  1  one-cycle pulse; `snap_value` is updated.
- `snap_value`  out  32  last snapshot, {high, low}.

## Operation
- All outputs are registered. Reset values: `m_chipselect`=0, `m_write_n`=1, `m_address`=0, `m_writedata`=0, `busy`=0, `tick_pulse`=0, `tick_count`=0, `snap_valid`=0, `snap_value`=0. The state machine resets to IDLE.
- Every bus access lasts exactly one cycle; the slave has no waitrequest. The bus is idle between accesses (`m_chipselect`=0, `m_write_n`=1).
- State machine:
  - IDLE: accepted `cfg_start` -> WR_PL.
  - WR_PL: write addr 2 with `period[15:0]` -> WR_PH.
  - WR_PH: write addr 3 with `period[31:16]` -> WR_CTRL.
  - WR_CTRL: write addr 1 with `{12'b0, CTRL_RUN}` -> RUN.
  - RUN, priority `cfg_stop` > `irq_in` > `snap_req`:
    - `cfg_stop` -> STOP.
    - `irq_in` -> ACK.
    - `snap_req` -> SN_WR.
  - ACK: write addr 0 with data 0. `tick_count` += 1 (wraps 0xFFFFFFFF -> 0) and `tick_pulse` pulses -> RUN.
  - SN_WR: write addr 4 with data 0 -> SN_RL.
  - SN_RL: read addr 4 -> SN_RH.
  - SN_RH: read addr 5; capture `m_readdata` as low half -> SN_CAP.
  - SN_CAP: bus idle; capture `m_readdata` as high half, update `snap_value`, pulse `snap_valid` -> RUN.
  - STOP: write addr 1 with `{12'b0, CTRL_STOP}` -> IDLE.
- Requests arriving outside their accepting state are dropped, not queued. A pending IRQ that is still high on return to RUN is serviced next. A `snap_req` that loses arbitration to `irq_in` in the same cycle is dropped.
- `cfg_period`=0 is accepted and programmed as-is; the timer then times out every cycle, and each timeout is serviced whenever the sequencer is in RUN.
- `tick_count` holds its value across STOP/start; only `reset` clears it.
- `reset` asserted mid-sequence returns to IDLE on the next edge, and the bus goes idle that cycle. No partial write completes afterwards.

## Timing
- Accepted `cfg_start` at edge E0: WR_PL write in cycle 1, WR_PH in cycle 2, WR_CTRL in cycle 3, RUN from cycle 4.
- IRQ service: `irq_in` sampled high at edge E -> status write in the next cycle. The slave clears its IRQ at the end of that cycle, so `irq_in` is low when RUN resumes and no guard cycle is needed. `tick_pulse` and the incremented `tick_count` are visible in the cycle after the ACK write.
- Snapshot: `snap_req` sampled at E0 -> addr-4 write in cycle 1, addr-4 read in cycle 2, addr-5 read in cycle 3, high half arrives in cycle 4. `snap_valid`=1 in cycle 5.
- Stop: `cfg_stop` sampled at E0 -> control write in cycle 1, `busy`=0 from cycle 2.
- Turnaround: the worst-case IRQ latency from RUN is 4 cycles (snapshot in progress) plus 1 cycle for the ACK write.

## Structure
- Shared package `timer_regs_pkg`:
  - Address constants: STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3, SNAPL=4, SNAPH=5.
  - Control bit indices: ITO=0, CONT=1, START=2, STOP=3.
  - The state enum type.
- Single module; no sub-module. The FSM, bus output registers and counters live together.

## Test plan
- Start with period 0x0001_86A0 -> bus shows writes (2, 0x86A0), (3, 0x0001), (1, 0x0007) on consecutive cycles; `busy`=1.
- Bench timer model asserts `irq_in` 3 times -> 3 status writes (addr 0, data 0); `tick_count`=3; 3 `tick_pulse`.
- `snap_req` in RUN, model snapshot 0x1234_5678 -> write addr 4, reads addr 4 then addr 5; `snap_valid` in cycle 5 with `snap_value`=0x12345678.
- `cfg_stop` and `irq_in` in the same cycle -> control write 0x0008, no status write, `busy` low 2 cycles later.
- Preload `tick_count`=0xFFFFFFFF via 2^32-1 modelled IRQs (or a forced value) -> next IRQ gives `tick_count`=0.
- Assert `reset` during WR_PH -> next cycle `m_chipselect`=0, state IDLE, all outputs at reset values; a new `cfg_start` reprograms from WR_PL.

Source files
------------

// File: rtl/timer_regs_pkg.sv
// Register map, control bit positions and sequencer state type for the
// 16-bit interval-timer slave.
package timer_regs_pkg;

   localparam logic [2:0] ADDR_STATUS  = 3'd0;
   localparam logic [2:0] ADDR_CONTROL = 3'd1;
   localparam logic [2:0] ADDR_PERIODL = 3'd2;
   localparam logic [2:0] ADDR_PERIODH = 3'd3;
   localparam logic [2:0] ADDR_SNAPL   = 3'd4;
   localparam logic [2:0] ADDR_SNAPH   = 3'd5;

   localparam int BIT_ITO   = 0;
   localparam int BIT_CONT  = 1;
   localparam int BIT_START = 2;
   localparam int BIT_STOP  = 3;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_PL,
      ST_WR_PH,
      ST_WR_CTRL,
      ST_RUN,
      ST_ACK,
      ST_SN_WR,
      ST_SN_RL,
      ST_SN_RH,
      ST_SN_CAP,
      ST_STOP
   } state_t;

endpackage

// File: rtl/timer_host_master.sv
// Avalon-MM master that programs the interval timer, services its timeout
// IRQs, counts ticks and takes counter snapshots without CPU involvement.
module timer_host_master
   import timer_regs_pkg::*;
#(
   parameter logic [3:0] CTRL_RUN  = 4'h7,
   parameter logic [3:0] CTRL_STOP = 4'h8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cfg_start,
   input  logic        cfg_stop,
   input  logic [31:0] cfg_period,
   input  logic        snap_req,
   output logic [2:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [15:0] m_writedata,
   input  logic [15:0] m_readdata,
   input  logic        irq_in,
   output logic        busy,
   output logic        tick_pulse,
   output logic [31:0] tick_count,
   output logic        snap_valid,
   output logic [31:0] snap_value
);

   state_t      state;
   logic [31:0] period_reg;
   logic [15:0] snap_low_reg;

   // Bus outputs are loaded on the edge that enters the state performing the
   // access, so every access is visible for exactly that state's cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         period_reg   <= '0;
         snap_low_reg <= '0;
         m_address    <= '0;
         m_chipselect <= 1'b0;
         m_write_n    <= 1'b1;
         m_writedata  <= '0;
         busy         <= 1'b0;
         tick_pulse   <= 1'b0;
         tick_count   <= '0;
         snap_valid   <= 1'b0;
         snap_value   <= '0;
      end else begin
         m_chipselect <= 1'b0;
         m_write_n    <= 1'b1;
         tick_pulse   <= 1'b0;
         snap_valid   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cfg_start) begin
                  period_reg   <= cfg_period;
                  m_chipselect <= 1'b1;
                  m_write_n    <= 1'b0;
                  m_address    <= ADDR_PERIODL;
                  m_writedata  <= cfg_period[15:0];
                  busy         <= 1'b1;
                  state        <= ST_WR_PL;
               end
            end
            ST_WR_PL: begin
               m_chipselect <= 1'b1;
               m_write_n    <= 1'b0;
               m_address    <= ADDR_PERIODH;
               m_writedata  <= period_reg[31:16];
               state        <= ST_WR_PH;
            end
            ST_WR_PH: begin
               m_chipselect <= 1'b1;
               m_write_n    <= 1'b0;
               m_address    <= ADDR_CONTROL;
               m_writedata  <= {12'b0, CTRL_RUN};
               state        <= ST_WR_CTRL;
            end
            ST_WR_CTRL: state <= ST_RUN;
            ST_RUN: begin
               // Stop wins over a pending IRQ; a snapshot losing to an IRQ is dropped.
               if (cfg_stop) begin
                  m_chipselect <= 1'b1;
                  m_write_n    <= 1'b0;
                  m_address    <= ADDR_CONTROL;
                  m_writedata  <= {12'b0, CTRL_STOP};
                  state        <= ST_STOP;
               end else if (irq_in) begin
                  m_chipselect <= 1'b1;
                  m_write_n    <= 1'b0;
                  m_address    <= ADDR_STATUS;
                  m_writedata  <= '0;
                  state        <= ST_ACK;
               end else if (snap_req) begin
                  m_chipselect <= 1'b1;
                  m_write_n    <= 1'b0;
                  m_address    <= ADDR_SNAPL;
                  m_writedata  <= '0;
                  state        <= ST_SN_WR;
               end
            end
            ST_ACK: begin
               tick_count <= tick_count + 32'd1;
               tick_pulse <= 1'b1;
               state      <= ST_RUN;
            end
            ST_SN_WR: begin
               m_chipselect <= 1'b1;
               m_address    <= ADDR_SNAPL;
               state        <= ST_SN_RL;
            end
            ST_SN_RL: begin
               m_chipselect <= 1'b1;
               m_address    <= ADDR_SNAPH;
               state        <= ST_SN_RH;
            end
            // Read data lags its read cycle by one, hence the capture offset.
            ST_SN_RH: begin
               snap_low_reg <= m_readdata;
               state        <= ST_SN_CAP;
            end
            ST_SN_CAP: begin
               snap_value <= {m_readdata, snap_low_reg};
               snap_valid <= 1'b1;
               state      <= ST_RUN;
            end
            ST_STOP: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_timer_host_master.sv
// Self-checking bench for timer_host_master: timer slave model plus a
// scoreboard of expected bus accesses checked on every chipselect cycle.
module tb_timer_host_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cfg_start = 1'b0;
   logic        cfg_stop = 1'b0;
   logic [31:0] cfg_period = '0;
   logic        snap_req = 1'b0;
   logic [2:0]  m_address;
   logic        m_chipselect;
   logic        m_write_n;
   logic [15:0] m_writedata;
   logic [15:0] m_readdata;
   logic        irq_in;
   logic        busy;
   logic        tick_pulse;
   logic [31:0] tick_count;
   logic        snap_valid;
   logic [31:0] snap_value;

   int checks = 0;
   int errors = 0;
   int pulse_cnt = 0;
   logic [31:0] exp_ticks = '0;

   typedef struct packed {
      logic [2:0]  addr;
      logic        wr;
      logic [15:0] data;
   } bus_t;
   bus_t exp_q[$];

   logic [31:0] snap_model = '0;
   logic        irq_reg = 1'b0;
   logic        irq_set = 1'b0;
   logic        irq_clr = 1'b0;
   logic [15:0] rdata = 16'hDEAD;

   assign irq_in     = irq_reg;
   assign m_readdata = rdata;

   always #5 clk = ~clk;

   timer_host_master dut (
      .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
      .cfg_period(cfg_period), .snap_req(snap_req), .m_address(m_address),
      .m_chipselect(m_chipselect), .m_write_n(m_write_n), .m_writedata(m_writedata),
      .m_readdata(m_readdata), .irq_in(irq_in), .busy(busy), .tick_pulse(tick_pulse),
      .tick_count(tick_count), .snap_valid(snap_valid), .snap_value(snap_value)
   );

   // Timer slave: registered read data, IRQ cleared by a status write.
   always @(posedge clk) begin
      if (irq_set) irq_reg <= 1'b1;
      else if (irq_clr || (m_chipselect && !m_write_n && m_address == 3'd0)) irq_reg <= 1'b0;
      if (m_chipselect && m_write_n && m_address == 3'd4) rdata <= snap_model[15:0];
      else if (m_chipselect && m_write_n && m_address == 3'd5) rdata <= snap_model[31:16];
      else rdata <= 16'hDEAD;
   end

   always @(negedge clk) begin : monitor
      bus_t e;
      if (tick_pulse) pulse_cnt++;
      if (m_chipselect) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL bus_unexpected: addr=%0d write_n=%b data=%h, required no access",
                     m_address, m_write_n, m_writedata);
         end else begin
            e = exp_q.pop_front();
            if (m_address !== e.addr || m_write_n !== ~e.wr || (e.wr && m_writedata !== e.data)) begin
               errors++;
               $display("FAIL bus_access: got addr=%0d write_n=%b data=%h, required addr=%0d write_n=%b data=%h",
                        m_address, m_write_n, m_writedata, e.addr, ~e.wr, e.data);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] a, input logic w, input logic [15:0] d);
      bus_t e;
      e.addr = a; e.wr = w; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      @(negedge clk);
      checks++;
      if ({m_chipselect, m_write_n, m_address, m_writedata, busy, tick_pulse, snap_valid}
          !== {1'b0, 1'b1, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs: cs=%b wn=%b addr=%0d wd=%h busy=%b tp=%b sv=%b, required 0 1 0 0000 0 0 0",
                  m_chipselect, m_write_n, m_address, m_writedata, busy, tick_pulse, snap_valid);
      end
      checks++;
      if (tick_count !== 32'd0 || snap_value !== 32'd0) begin
         errors++;
         $display("FAIL reset_counters: tick_count=%h snap_value=%h, required 0 0", tick_count, snap_value);
      end
      step();
      reset = 1'b0;
   endtask

   task automatic test_start(input logic [31:0] p);
      push(3'd2, 1'b1, p[15:0]);
      push(3'd3, 1'b1, p[31:16]);
      push(3'd1, 1'b1, 16'h0007);
      step();
      cfg_period = p;
      cfg_start  = 1'b1;
      step();
      cfg_start  = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || m_chipselect !== 1'b1 || m_address !== 3'd2) begin
         errors++;
         $display("FAIL start_cycle1: busy=%b cs=%b addr=%0d, required 1 1 2", busy, m_chipselect, m_address);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL start_done: pending=%0d busy=%b, required 0 1", exp_q.size(), busy);
      end
   endtask

   task automatic irq_once();
      bit ok = 0;
      exp_ticks = exp_ticks + 32'd1;
      push(3'd0, 1'b1, 16'h0000);
      step();
      irq_set = 1'b1;
      step();
      irq_set = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (tick_pulse) ok = 1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL irq_tick: no tick_pulse within 20 cycles, required pulse with count %h", exp_ticks);
      end else if (tick_count !== exp_ticks) begin
         errors++;
         $display("FAIL irq_tick: tick_count=%h, required %h", tick_count, exp_ticks);
      end
   endtask

   task automatic test_irq();
      int start_pulses = pulse_cnt;
      repeat (3) irq_once();
      step(); step();
      checks++;
      if (pulse_cnt - start_pulses != 3 || tick_count !== 32'd3 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL irq_three: pulses=%0d tick_count=%h pending=%0d, required 3 3 0",
                  pulse_cnt - start_pulses, tick_count, exp_q.size());
      end
   endtask

   task automatic test_snap(input logic [31:0] v);
      bit early = 0;
      snap_model = v;
      push(3'd4, 1'b1, 16'h0000);
      push(3'd4, 1'b0, 16'h0000);
      push(3'd5, 1'b0, 16'h0000);
      step();
      snap_req = 1'b1;
      step();
      snap_req = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k < 5 && snap_valid) early = 1;
         if (k == 1) begin
            checks++;
            if (m_chipselect !== 1'b1 || m_write_n !== 1'b0 || m_address !== 3'd4) begin
               errors++;
               $display("FAIL snap_cycle1: cs=%b wn=%b addr=%0d, required 1 0 4", m_chipselect, m_write_n, m_address);
            end
         end
      end
      checks++;
      if (early || snap_valid !== 1'b1 || snap_value !== v) begin
         errors++;
         $display("FAIL snap_value: early=%0d valid=%b value=%h, required 0 1 %h", early, snap_valid, snap_value, v);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL snap_bus: pending=%0d, required 0", exp_q.size());
      end
   endtask

   task automatic test_stop_with_irq();
      push(3'd1, 1'b1, 16'h0008);
      step();
      irq_set = 1'b1;
      step();
      irq_set  = 1'b0;
      cfg_stop = 1'b1;
      step();
      cfg_stop = 1'b0;
      @(negedge clk);
      checks++;
      if (m_chipselect !== 1'b1 || m_address !== 3'd1 || m_writedata !== 16'h0008 || busy !== 1'b1) begin
         errors++;
         $display("FAIL stop_write: cs=%b addr=%0d data=%h busy=%b, required 1 1 0008 1",
                  m_chipselect, m_address, m_writedata, busy);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL stop_busy: busy=%b, required 0", busy);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (tick_count !== exp_ticks || exp_q.size() != 0) begin
         errors++;
         $display("FAIL stop_no_ack: tick_count=%h pending=%0d, required %h 0", tick_count, exp_q.size(), exp_ticks);
      end
      step();
      irq_clr = 1'b1;
      step();
      irq_clr = 1'b0;
   endtask

   task automatic test_wrap();
      test_start(32'h0000_0000);
      checks++;
      if (tick_count !== exp_ticks) begin
         errors++;
         $display("FAIL count_held: tick_count=%h, required %h", tick_count, exp_ticks);
      end
      step();
      force dut.tick_count = 32'hFFFF_FFFF;
      step();
      release dut.tick_count;
      exp_ticks = 32'hFFFF_FFFF;
      irq_once();
      irq_once();
   endtask

   task automatic test_reset_mid();
      push(3'd1, 1'b1, 16'h0008);
      step();
      cfg_stop = 1'b1;
      step();
      cfg_stop = 1'b0;
      repeat (3) step();
      push(3'd2, 1'b1, 16'hBEEF);
      push(3'd3, 1'b1, 16'hCAFE);
      cfg_period = 32'hCAFE_BEEF;
      cfg_start  = 1'b1;
      step();
      cfg_start = 1'b0;
      step();
      reset = 1'b1;
      step();
      @(negedge clk);
      checks++;
      if ({m_chipselect, m_write_n, m_address, m_writedata, busy, tick_pulse, snap_valid}
          !== {1'b0, 1'b1, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0}
          || tick_count !== 32'd0 || snap_value !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid: cs=%b wn=%b addr=%0d busy=%b tick_count=%h snap_value=%h, required idle and zeros",
                  m_chipselect, m_write_n, m_address, busy, tick_count, snap_value);
      end
      step();
      reset = 1'b0;
      exp_ticks = '0;
      step(); step();
      checks++;
      if (exp_q.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_quiet: pending=%0d busy=%b, required 0 0", exp_q.size(), busy);
      end
      test_start(32'hCAFE_BEEF);
   endtask

   initial begin
      test_reset();
      test_start(32'h0001_86A0);
      test_irq();
      test_snap(32'h1234_5678);
      test_snap(32'hA5A5_0F0F);
      test_stop_with_irq();
      test_wrap();
      test_reset_mid();
      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
